// File: rtl/one_sec_timer.sv
// Enable-gated timebase: emits a one-cycle registered strobe every TICKS enabled clocks.
// Dropping En or asserting rst abandons the partial interval and restarts from zero.
module one_sec_timer #(
   parameter int unsigned TICKS = 50_000_000,
   localparam int unsigned CNT_W = (TICKS <= 1) ? 1 : $clog2(TICKS)
) (
   input  logic En,
   output logic One_sec_timeout,
   input  logic clk,
   input  logic rst
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

   logic [CNT_W-1:0] cnt;

   // Wrap and strobe share one edge, so the period has no dead cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt             <= '0;
         One_sec_timeout <= 1'b0;
      end else if (!En) begin
         cnt             <= '0;
         One_sec_timeout <= 1'b0;
      end else if (cnt == LAST) begin
         cnt             <= '0;
         One_sec_timeout <= 1'b1;
      end else begin
         cnt             <= cnt + 1'b1;
         One_sec_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_one_sec_timer.sv
// Bench for one_sec_timer: TICKS=10 and TICKS=1 instances share stimulus and are
// compared each cycle against a run-length model of consecutive enabled edges.
module tb_one_sec_timer;

   logic clk;
   logic rst;
   logic en;
   logic out10;
   logic out1;

   int total;
   int bad;
   int run_len;

   one_sec_timer #(.TICKS(10)) u_dut10 (
      .En              (en),
      .One_sec_timeout (out10),
      .clk             (clk),
      .rst             (rst)
   );

   one_sec_timer #(.TICKS(1)) u_dut1 (
      .En              (en),
      .One_sec_timeout (out1),
      .clk             (clk),
      .rst             (rst)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge with the given inputs; model advances, then both DUTs are checked.
   task automatic step(input logic r, input logic e, input string tag);
      logic exp10;
      logic exp1;
      rst = r;
      en  = e;
      @(posedge clk);
      if (r || !e) run_len = 0;
      else         run_len++;
      exp10 = (run_len > 0) && (run_len % 10 == 0);
      exp1  = (run_len > 0);
      #1;
      chk({tag, "_out10"}, {31'd0, out10}, {31'd0, exp10});
      chk({tag, "_cnt10"}, {28'd0, u_dut10.cnt}, 32'(run_len % 10));
      chk({tag, "_out1"},  {31'd0, out1},  {31'd0, exp1});
   endtask

   task automatic run(input int n, input logic r, input logic e, input string tag);
      for (int i = 0; i < n; i++) step(r, e, tag);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      run_len = 0;
      rst     = 1'b1;
      en      = 1'b1;

      // reset dominates En
      run(3, 1'b1, 1'b1, "reset");

      // basic timing: strobes on enabled edges 10, 20, 30
      run(35, 1'b0, 1'b1, "basic");

      // enable gating mid-interval
      run(1, 1'b1, 1'b1, "pre_gate_rst");
      run(6, 1'b0, 1'b1, "gate_run");
      run(1, 1'b0, 1'b0, "gate_off");
      run(12, 1'b0, 1'b1, "gate_rerun");

      // reset mid-interval
      run(1, 1'b1, 1'b0, "pre_mid_rst");
      run(7, 1'b0, 1'b1, "mid_run");
      run(2, 1'b1, 1'b1, "mid_rst");
      run(12, 1'b0, 1'b1, "mid_rerun");

      // collisions on the edge that would fire the strobe
      run(1, 1'b1, 1'b1, "pre_col");
      run(9, 1'b0, 1'b1, "col_run");
      run(1, 1'b1, 1'b1, "col_rst");
      run(9, 1'b0, 1'b1, "col_run2");
      run(1, 1'b0, 1'b0, "col_en");
      run(11, 1'b0, 1'b1, "col_rerun");

      // TICKS=1 corner: drops one edge after En falls
      run(1, 1'b0, 1'b0, "t1_off");
      run(3, 1'b0, 1'b1, "t1_on");

      // randomized: mostly enabled so strobes still occur
      for (int i = 0; i < 400; i++) begin
         logic r;
         logic e;
         r = ($urandom_range(0, 39) == 0);
         e = ($urandom_range(0, 15) != 0);
         step(r, e, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
